// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array feeder: message layout helpers and the
// feeder state encoding.
package pe_array_pkg;

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Flag positions are offsets above the data field (flush is the MSB).
  localparam int FLUSH_BIT_OFS  = 1;
  localparam int WEIGHT_BIT_OFS = 0;

  function automatic int msg_width(input int bit_width);
    return bit_width + 2;
  endfunction

endpackage

// File: rtl/pe_array_feeder_if.sv
// Vector input and per-row message output bundle of the PE array feeder.
// Signal names keep the feeder's own i_/o_ view.
interface pe_array_feeder_if
  import pe_array_pkg::*;
#(
  parameter int NUM_ROWS  = 2,
  parameter int BIT_WIDTH = 8
) ();

  localparam int MSG_WIDTH = msg_width(BIT_WIDTH);

  logic [NUM_ROWS*BIT_WIDTH-1:0] i_vec_data;
  logic                          i_vec_is_weight;
  logic                          i_vec_last;
  logic                          i_vec_val;
  logic                          o_vec_rdy;
  logic [MSG_WIDTH-1:0]          o_msg_send_msg [NUM_ROWS-1:0];
  logic [NUM_ROWS-1:0]           o_msg_send_val;
  logic [NUM_ROWS-1:0]           i_msg_send_rdy;
  logic                          o_busy;

  modport master (
    output i_vec_data, i_vec_is_weight, i_vec_last, i_vec_val, i_msg_send_rdy,
    input  o_vec_rdy, o_msg_send_msg, o_msg_send_val, o_busy
  );

  modport slave (
    input  i_vec_data, i_vec_is_weight, i_vec_last, i_vec_val, i_msg_send_rdy,
    output o_vec_rdy, o_msg_send_msg, o_msg_send_val, o_busy
  );

endinterface

// File: rtl/pe_msg_fifo.sv
// Per-row message FIFO; occupancy count separates full from empty and the
// head reads as zero whenever the FIFO is empty.
module pe_msg_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == CNT_W'(0));
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents are don't-care until counted as occupied.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_array_feeder.sv
// Feeds weight/activation vectors into per-row message FIFOs and appends
// NUM_COLS flush messages after the last activation vector of a matrix.
module pe_array_feeder
  import pe_array_pkg::*;
#(
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 2,
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pe_array_feeder_if.slave bus
);

  localparam int MSG_WIDTH  = msg_width(BIT_WIDTH);
  localparam int FLUSH_POS  = BIT_WIDTH + FLUSH_BIT_OFS;
  localparam int WEIGHT_POS = BIT_WIDTH + WEIGHT_BIT_OFS;
  localparam int CNT_W      = $clog2(NUM_COLS + 1);

  state_e              r_state;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                r_live;
  logic [NUM_ROWS-1:0] w_full;
  logic [NUM_ROWS-1:0] w_empty;
  logic                w_any_full;
  logic                w_all_empty;
  logic                w_vec_rdy;
  logic                w_accept;
  logic                w_flush_push;
  logic                w_push;

  assign w_any_full   = |w_full;
  assign w_all_empty  = &w_empty;
  // r_live holds ready low for the first cycle out of reset.
  assign w_vec_rdy    = r_live && (r_state == STREAM) && !w_any_full;
  assign w_accept     = bus.i_vec_val && w_vec_rdy;
  assign w_flush_push = (r_state == FLUSH) && !w_any_full;
  assign w_push       = w_accept || w_flush_push;

  assign bus.o_vec_rdy      = w_vec_rdy;
  assign bus.o_msg_send_val = ~w_empty;
  assign bus.o_busy         = !w_all_empty || (r_state != STREAM);

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [MSG_WIDTH-1:0] w_msg;
    logic [MSG_WIDTH-1:0] w_head;
    logic                 w_pop;

    // Select the flush marker or this row's slice of the incoming vector.
    always_comb begin
      w_msg = '0;
      if (w_flush_push) begin
        w_msg[FLUSH_POS] = 1'b1;
      end else begin
        w_msg[WEIGHT_POS]      = bus.i_vec_is_weight;
        w_msg[BIT_WIDTH-1:0]   = bus.i_vec_data[r*BIT_WIDTH +: BIT_WIDTH];
      end
    end

    assign w_pop = !w_empty[r] && bus.i_msg_send_rdy[r];

    pe_msg_fifo #(
      .WIDTH (MSG_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (w_msg),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty[r]),
      .o_full  (w_full[r])
    );

    assign bus.o_msg_send_msg[r] = w_head;
  end

  // Stream / flush / drain sequencing.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= STREAM;
      r_flush_cnt <= '0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        STREAM: begin
          if (w_accept && bus.i_vec_last && !bus.i_vec_is_weight) begin
            r_state     <= FLUSH;
            r_flush_cnt <= CNT_W'(NUM_COLS);
          end
        end
        FLUSH: begin
          if (w_flush_push) begin
            r_flush_cnt <= r_flush_cnt - CNT_W'(1);
            if (r_flush_cnt == CNT_W'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_all_empty) begin
            r_state <= STREAM;
          end
        end
        default: begin
          r_state     <= STREAM;
          r_flush_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder at default parameters (2 rows, 2 cols,
// 8-bit data, depth 4); emitted messages are captured per row.
module tb_pe_array_feeder;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int BW = 8;
  localparam int DP = 4;
  localparam int MW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [MW-1:0] got0[$];
  logic [MW-1:0] got1[$];

  always #5 clk = ~clk;

  pe_array_feeder_if #(.NUM_ROWS(NR), .BIT_WIDTH(BW)) bus ();

  pe_array_feeder #(
    .NUM_ROWS  (NR),
    .NUM_COLS  (NC),
    .BIT_WIDTH (BW),
    .DEPTH     (DP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  // Inputs only change just after posedge, so a handshake seen at negedge
  // is the one the next posedge completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_msg_send_val[0] && bus.i_msg_send_rdy[0]) got0.push_back(bus.o_msg_send_msg[0]);
      if (bus.o_msg_send_val[1] && bus.i_msg_send_rdy[1]) got1.push_back(bus.o_msg_send_msg[1]);
    end
  end

  task automatic drive_vec(input logic [15:0] d, input logic w, input logic last, input logic v);
    bus.i_vec_data      = d;
    bus.i_vec_is_weight = w;
    bus.i_vec_last      = last;
    bus.i_vec_val       = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_msg_send_val !== 2'b00) begin n_fail++; $display("FAIL rst_val: got %b want 00", bus.o_msg_send_val); end
    n_tests++; if (bus.o_msg_send_msg[0] !== 10'h000 || bus.o_msg_send_msg[1] !== 10'h000) begin n_fail++; $display("FAIL rst_msg: got %h %h want 000 000", bus.o_msg_send_msg[0], bus.o_msg_send_msg[1]); end
    n_tests++; if (bus.o_vec_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b want 0", bus.o_vec_rdy); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy_release: got %b want 0", bus.o_vec_rdy); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy_rise: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
  endtask

  task automatic test_weight_load();
    logic rdy_ok;
    got0.delete(); got1.delete();
    bus.i_msg_send_rdy = 2'b11;
    drive_vec(16'h0001, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL wl_rdy0: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0100, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_msg_send_val !== 2'b11 || bus.o_msg_send_msg[0] !== 10'h101) begin n_fail++; $display("FAIL wl_latency: got val %b msg0 %h want 11 101", bus.o_msg_send_val, bus.o_msg_send_msg[0]); end
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL wl_rdy1: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    rdy_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.o_vec_rdy !== 1'b1) rdy_ok = 1'b0;
      next_cycle();
    end
    n_tests++; if (rdy_ok !== 1'b1) begin n_fail++; $display("FAIL wl_rdy_hold: got drop want always 1"); end
    n_tests++; if (got0.size() != 2 || got0[0] !== 10'h101 || got0[1] !== 10'h100) begin n_fail++; $display("FAIL wl_row0: got %p want 101,100", got0); end
    n_tests++; if (got1.size() != 2 || got1[0] !== 10'h100 || got1[1] !== 10'h101) begin n_fail++; $display("FAIL wl_row1: got %p want 100,101", got1); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL wl_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_activation();
    int   zeros;
    logic seen;
    logic drain_ok;
    got0.delete(); got1.delete();
    bus.i_msg_send_rdy = 2'b11;
    drive_vec(16'h0301, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL act_rdy0: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0402, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL act_rdy1: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    zeros = 0; seen = 1'b0; drain_ok = 1'b0;
    while (!seen && zeros < 12) begin
      @(negedge clk);
      if (bus.o_vec_rdy === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (zeros == 3 && bus.o_msg_send_val === 2'b00 && bus.o_busy === 1'b1) drain_ok = 1'b1;
        zeros++;
      end
      next_cycle();
    end
    n_tests++; if (zeros != 4) begin n_fail++; $display("FAIL act_rdy_low_cycles: got %0d want 4", zeros); end
    n_tests++; if (drain_ok !== 1'b1) begin n_fail++; $display("FAIL act_drain_busy: got %b want 1", drain_ok); end
    n_tests++; if (got0.size() != 4 || got0[0] !== 10'h001 || got0[1] !== 10'h002 || got0[2] !== 10'h200 || got0[3] !== 10'h200) begin n_fail++; $display("FAIL act_row0: got %p want 001,002,200,200", got0); end
    n_tests++; if (got1.size() != 4 || got1[0] !== 10'h003 || got1[1] !== 10'h004 || got1[2] !== 10'h200 || got1[3] !== 10'h200) begin n_fail++; $display("FAIL act_row1: got %p want 003,004,200,200", got1); end
  endtask

  task automatic test_backpressure();
    logic acc_ok;
    got0.delete(); got1.delete();
    bus.i_msg_send_rdy = 2'b01;
    acc_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_vec({8'h20 + 8'(i), 8'h10 + 8'(i)}, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.o_vec_rdy !== 1'b1) acc_ok = 1'b0;
      next_cycle();
    end
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    n_tests++; if (acc_ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got rdy drop want 4 accepts"); end
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_low: got %b want 0", bus.o_vec_rdy); end
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    n_tests++; if (got0.size() != 4 || got0[0] !== 10'h010 || got0[3] !== 10'h013) begin n_fail++; $display("FAIL bp_row0_drain: got %p want 010..013", got0); end
    n_tests++; if (bus.o_msg_send_val !== 2'b10 || bus.o_msg_send_msg[1] !== 10'h020) begin n_fail++; $display("FAIL bp_row1_hold: got val %b msg1 %h want 10 020", bus.o_msg_send_val, bus.o_msg_send_msg[1]); end
    n_tests++; if (bus.o_vec_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_still_low: got %b want 0", bus.o_vec_rdy); end
    next_cycle();
    // Full row1 with a pop and a push offered in the same cycle.
    bus.i_msg_send_rdy = 2'b11;
    drive_vec(16'h2414, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b0) begin n_fail++; $display("FAIL fp_no_pass_through: got %b want 0", bus.o_vec_rdy); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL fp_rdy_back: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) next_cycle();
    n_tests++; if (got1.size() != 5 || got1[0] !== 10'h020 || got1[1] !== 10'h021 || got1[2] !== 10'h022 || got1[3] !== 10'h023 || got1[4] !== 10'h024) begin n_fail++; $display("FAIL bp_row1: got %p want 020..024", got1); end
    n_tests++; if (got0.size() != 5 || got0[4] !== 10'h014) begin n_fail++; $display("FAIL bp_row0: got %p want 010..014", got0); end
  endtask

  task automatic test_reset_mid_flush();
    bus.i_msg_send_rdy = 2'b11;
    drive_vec(16'h0605, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL rmf_rdy: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_msg_send_val !== 2'b00 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rmf_clear: got val %b busy %b want 00 0", bus.o_msg_send_val, bus.o_busy); end
    n_tests++; if (bus.o_vec_rdy !== 1'b0 || bus.o_msg_send_msg[0] !== 10'h000) begin n_fail++; $display("FAIL rmf_rdy_msg: got rdy %b msg0 %h want 0 000", bus.o_vec_rdy, bus.o_msg_send_msg[0]); end
    got0.delete(); got1.delete();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) next_cycle();
    drive_vec(16'h0807, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.o_vec_rdy !== 1'b1) begin n_fail++; $display("FAIL rmf_rdy_after: got %b want 1", bus.o_vec_rdy); end
    next_cycle();
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.o_msg_send_val !== 2'b11 || bus.o_msg_send_msg[0] !== 10'h007 || bus.o_msg_send_msg[1] !== 10'h008) begin n_fail++; $display("FAIL rmf_head: got val %b msg %h %h want 11 007 008", bus.o_msg_send_val, bus.o_msg_send_msg[0], bus.o_msg_send_msg[1]); end
    for (int i = 0; i < 4; i++) next_cycle();
    n_tests++; if (got0.size() != 1 || got0[0] !== 10'h007) begin n_fail++; $display("FAIL rmf_row0: got %p want 007 only", got0); end
    n_tests++; if (got1.size() != 1 || got1[0] !== 10'h008) begin n_fail++; $display("FAIL rmf_row1: got %p want 008 only", got1); end
  endtask

  initial begin
    bus.i_msg_send_rdy = 2'b11;
    drive_vec(16'h0000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_weight_load();
    test_activation();
    test_backpressure();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
